// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Hardware program loader for the byte-addressed instruction RAM. It accepts a
// framed byte stream over a valid/ready handshake and issues one RAM byte
// write per payload byte. The pipeline stays in reset (cpu_hold=1) until the
// whole image has been written and accepted.
//
// Frame: header byte N (word count), 4*N payload bytes, and, when
// LOADER_CHECKSUM_EN is defined, one trailing XOR checksum byte.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : checksum byte is expected and checked (CSUM state present)
//   undefined : PAYLOAD goes straight to DONE after the last byte
//
// Ports:
//   CLK        in   system clock, rising edge
//   CLR        in   synchronous active-high reset
//   start      in   load start pulse (honoured in IDLE, DONE, ERR)
//   in_valid   in   in_data holds a valid stream byte
//   in_data    in   [7:0] stream byte
//   in_ready   out  loader accepts a byte this cycle (registered)
//   mem_we     out  RAM byte write strobe (one cycle per payload byte)
//   mem_addr   out  [ADDR_W-1:0] RAM byte address
//   mem_data   out  [7:0] RAM write data
//   cpu_hold   out  pipeline held in reset while high
//   done       out  image loaded and accepted
//   error      out  load aborted
//   byte_count out  [ADDR_W:0] payload bytes written so far
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int CNT_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;
`endif

`ifdef LOADER_CHECKSUM_EN
    // Running XOR checksum: fold one payload byte into the accumulator.
    function automatic logic [7:0] csum_next(input logic [7:0] acc,
                                             input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t             state_r;
    state_t             state_next_s;

    logic               in_ready_r;
    logic               mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [7:0]         mem_data_r;
    logic               cpu_hold_r;
    logic               done_r;
    logic               error_r;
    logic [CNT_W-1:0]   byte_count_r;
    logic [CNT_W-1:0]   total_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif

    logic               accept_s;
    logic [31:0]        hdr_span_s;
    logic               hdr_bad_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               last_byte_s;

    // Handshake and header/payload decode shared by the FSM and datapath.
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        // Image end address computed wide so large N never aliases below MEM_DEPTH.
        hdr_span_s  = 32'(BASE_ADDR) + {22'd0, in_data, 2'b00};
        hdr_bad_s   = (in_data == 8'd0) || (hdr_span_s > 32'(MEM_DEPTH));
        count_inc_s = byte_count_r + {{ADDR_W{1'b0}}, 1'b1};
        last_byte_s = (count_inc_s == total_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    if (hdr_bad_s) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_PAYLOAD;
                    end
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s && last_byte_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next_s = ST_CSUM;
`else
                    state_next_s = ST_DONE;
`endif
                end else begin
                    state_next_s = ST_PAYLOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    if (in_data == csum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_ERR;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            in_ready_r <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
`ifdef LOADER_CHECKSUM_EN
            in_ready_r <= (state_next_s == ST_HDR) || (state_next_s == ST_PAYLOAD) ||
                          (state_next_s == ST_CSUM);
`else
            in_ready_r <= (state_next_s == ST_HDR) || (state_next_s == ST_PAYLOAD);
`endif
            cpu_hold_r <= (state_next_s != ST_DONE);
            done_r     <= (state_next_s == ST_DONE);
            error_r    <= (state_next_s == ST_ERR);
        end
    end

    // RAM write port, byte counter and frame length; address/data hold between writes.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_data_r   <= 8'd0;
            byte_count_r <= {CNT_W{1'b0}};
            total_r      <= {CNT_W{1'b0}};
        end else begin
            mem_we_r <= accept_s && (state_r == ST_PAYLOAD);
            if (accept_s && (state_r == ST_HDR) && !hdr_bad_s) begin
                byte_count_r <= {CNT_W{1'b0}};
                // Header check guarantees 4*N fits in the counter width.
                total_r      <= CNT_W'({in_data, 2'b00});
            end else if (accept_s && (state_r == ST_PAYLOAD)) begin
                mem_addr_r <= ADDR_W'(BASE_ADDR) + byte_count_r[ADDR_W-1:0];
                mem_data_r <= in_data;
                if (byte_count_r != total_r) begin
                    byte_count_r <= count_inc_s;
                end else begin
                    byte_count_r <= byte_count_r;
                end
            end else begin
                byte_count_r <= byte_count_r;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum accumulator: cleared on a good header, folds each payload byte.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            csum_r <= 8'd0;
        end else if (accept_s && (state_r == ST_HDR) && !hdr_bad_s) begin
            csum_r <= 8'd0;
        end else if (accept_s && (state_r == ST_PAYLOAD)) begin
            csum_r <= csum_next(csum_r, in_data);
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_data   = mem_data_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign error      = error_r;
    assign byte_count = byte_count_r;

endmodule
